// File: rtl/axis_seq_checker_pkg.sv
// Shared definitions for the AXI-Stream sequence checker: state encoding,
// counter widths and saturating increment helpers.
package axis_seq_checker_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    localparam int CNT_W  = 32;
    localparam int STAT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = ST_IDLE,
        S_RUN  = ST_RUN,
        S_HALT = ST_HALT
    } state_t;

    function automatic logic [CNT_W-1:0] sat_inc_cnt(input logic [CNT_W-1:0] value);
        if (value == {CNT_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    function automatic logic [STAT_W-1:0] sat_inc_stat(input logic [STAT_W-1:0] value);
        if (value == {STAT_W{1'b1}}) begin
            return value;
        end else begin
            return value + {{(STAT_W-1){1'b0}}, 1'b1};
        end
    endfunction

endpackage

// File: rtl/axis_seq_checker_if.sv
// AXI-Stream bundle between the FIFO master side and the sequence checker.
interface axis_seq_checker_if #(
    parameter int DATA_SIZE = 32
);
    logic [DATA_SIZE-1:0]   tdata;
    logic [DATA_SIZE/8-1:0] tstrb;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;

    modport master (output tdata, output tstrb, output tvalid, output tlast, input tready);
    modport slave  (input tdata, input tstrb, input tvalid, input tlast, output tready);
endinterface

// File: rtl/axis_seq_checker_throttle.sv
// Registered tready generator: while running, tready drops for one cycle
// out of every THROTTLE+1 so upstream backpressure paths get exercised.
module axis_ready_throttle #(
    parameter int THROTTLE = 0
) (
    input  logic aclk,
    input  logic areset,
    input  logic clear,
    input  logic run,
    input  logic run_next,
    output logic tready
);
    localparam int            TW    = (THROTTLE > 0) ? $clog2(THROTTLE + 1) : 1;
    localparam logic [TW-1:0] LIMIT = TW'(THROTTLE);

    logic [TW-1:0] cnt_r;
    logic [TW-1:0] cnt_next_s;
    logic          tready_r;
    logic          tready_next_s;

    // counter value of the next cycle and the tready level it implies
    always_comb begin
        cnt_next_s    = cnt_r;
        tready_next_s = 1'b0;
        if (clear) begin
            cnt_next_s = '0;
        end else if (run) begin
            if (cnt_r == LIMIT) begin
                cnt_next_s = '0;
            end else begin
                cnt_next_s = cnt_r + TW'(1);
            end
        end else begin
            cnt_next_s = cnt_r;
        end
        if (run_next && ((THROTTLE == 0) || (cnt_next_s != LIMIT))) begin
            tready_next_s = 1'b1;
        end else begin
            tready_next_s = 1'b0;
        end
    end

    // throttle state and registered tready
    always_ff @(posedge aclk) begin
        if (areset) begin
            cnt_r    <= '0;
            tready_r <= 1'b0;
        end else begin
            cnt_r    <= cnt_next_s;
            tready_r <= tready_next_s;
        end
    end

    assign tready = tready_r;

endmodule

// File: rtl/axis_seq_checker.sv
// AXI-Stream sink that checks an incrementing data sequence, full strobes and
// packet framing, and keeps saturating bring-up statistics.
module axis_seq_checker
    import axis_seq_checker_pkg::*;
#(
    parameter int                   DATA_SIZE   = 32,
    parameter logic [DATA_SIZE-1:0] SEED        = '0,
    parameter int                   PKT_LEN     = 16,
    parameter int                   THROTTLE    = 0,
    parameter int                   STOP_ON_ERR = 0
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic                 enable,
    input  logic                 clear,
    axis_seq_checker_if.slave    s00_axis,
    output logic [CNT_W-1:0]     beat_count,
    output logic [STAT_W-1:0]    pkt_count,
    output logic [STAT_W-1:0]    error_count,
    output logic                 err_flag,
    output logic [DATA_SIZE-1:0] first_err_data,
    output logic                 halted
);
    localparam logic [CNT_W-1:0] LAST_IDX = (PKT_LEN > 0) ? CNT_W'(PKT_LEN - 1) : {CNT_W{1'b0}};

    state_t               state_r;
    state_t               state_next_s;
    logic                 halted_r;
    logic [DATA_SIZE-1:0] expected_r;
    logic [CNT_W-1:0]     beat_in_pkt_r;
    logic [CNT_W-1:0]     beat_count_r;
    logic [STAT_W-1:0]    pkt_count_r;
    logic [STAT_W-1:0]    error_count_r;
    logic                 err_flag_r;
    logic [DATA_SIZE-1:0] first_err_data_r;

    logic accept_s;
    logic data_err_s;
    logic strb_err_s;
    logic frame_err_s;
    logic beat_err_s;

    assign accept_s   = s00_axis.tvalid & s00_axis.tready;
    assign data_err_s = (s00_axis.tdata != expected_r);
    assign strb_err_s = ~(&s00_axis.tstrb);
    assign beat_err_s = data_err_s | strb_err_s | frame_err_s;

    // tlast must coincide exactly with the last beat slot of a packet
    always_comb begin
        frame_err_s = 1'b0;
        if (PKT_LEN > 0) begin
            frame_err_s = s00_axis.tlast ^ (beat_in_pkt_r == LAST_IDX);
        end else begin
            frame_err_s = 1'b0;
        end
    end

    // next-state decode; clear overrides the normal transitions
    always_comb begin
        state_next_s = state_r;
        if (clear) begin
            if (enable && (state_r != S_HALT)) begin
                state_next_s = S_RUN;
            end else begin
                state_next_s = S_IDLE;
            end
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (enable) begin
                        state_next_s = S_RUN;
                    end else begin
                        state_next_s = S_IDLE;
                    end
                end
                S_RUN: begin
                    if (accept_s && beat_err_s && (STOP_ON_ERR != 0)) begin
                        state_next_s = S_HALT;
                    end else if (!enable) begin
                        state_next_s = S_IDLE;
                    end else begin
                        state_next_s = S_RUN;
                    end
                end
                S_HALT: begin
                    state_next_s = S_HALT;
                end
                default: begin
                    state_next_s = S_IDLE;
                end
            endcase
        end
    end

    // checker FSM with registered halted flag
    always_ff @(posedge aclk) begin
        if (areset) begin
            state_r  <= S_IDLE;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            halted_r <= (state_next_s == S_HALT);
        end
    end

    // sequence tracking and statistics; a beat taken during clear is dropped
    always_ff @(posedge aclk) begin
        if (areset || clear) begin
            expected_r       <= SEED;
            beat_in_pkt_r    <= '0;
            beat_count_r     <= '0;
            pkt_count_r      <= '0;
            error_count_r    <= '0;
            err_flag_r       <= 1'b0;
            first_err_data_r <= '0;
        end else if (accept_s) begin
            expected_r   <= s00_axis.tdata + DATA_SIZE'(1);
            beat_count_r <= sat_inc_cnt(beat_count_r);
            if (s00_axis.tlast) begin
                pkt_count_r   <= sat_inc_stat(pkt_count_r);
                beat_in_pkt_r <= '0;
            end else begin
                beat_in_pkt_r <= beat_in_pkt_r + CNT_W'(1);
            end
            if (beat_err_s) begin
                error_count_r <= sat_inc_stat(error_count_r);
                if (!err_flag_r) begin
                    err_flag_r       <= 1'b1;
                    first_err_data_r <= s00_axis.tdata;
                end
            end
        end
    end

    axis_ready_throttle #(
        .THROTTLE (THROTTLE)
    ) u_throttle (
        .aclk     (aclk),
        .areset   (areset),
        .clear    (clear),
        .run      (state_r == S_RUN),
        .run_next (state_next_s == S_RUN),
        .tready   (s00_axis.tready)
    );

    assign beat_count     = beat_count_r;
    assign pkt_count      = pkt_count_r;
    assign error_count    = error_count_r;
    assign err_flag       = err_flag_r;
    assign first_err_data = first_err_data_r;
    assign halted         = halted_r;

endmodule

// File: tb/tb_axis_seq_checker.sv
// Four checker instances with different parameter sets, driven by directed
// sequences, a vector table and random traffic against a behavioural model.
module tb_axis_seq_checker;

    localparam int N = 4;
    localparam logic [3:0][31:0] P_SEED = {32'hFFFF_FFFE, 32'h0, 32'h0, 32'h0};
    localparam logic [3:0][7:0]  P_LEN  = {8'd0, 8'd4, 8'd0, 8'd4};
    localparam logic [3:0][7:0]  P_THR  = {8'd2, 8'd0, 8'd3, 8'd0};
    localparam logic [3:0]       P_STOP = 4'b0100;

    logic aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        areset_v [N];
    logic        enable_v [N];
    logic        clear_v  [N];
    logic        tvalid_v [N];
    logic        tlast_v  [N];
    logic [31:0] tdata_v  [N];
    logic [3:0]  tstrb_v  [N];
    logic        tready_v [N];
    logic        flag_v   [N];
    logic        halted_v [N];
    logic [31:0] beat_v   [N];
    logic [31:0] first_v  [N];
    logic [15:0] pkt_v    [N];
    logic [15:0] err_v    [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        axis_seq_checker_if #(.DATA_SIZE(32)) bus ();
        assign bus.tdata    = tdata_v[g];
        assign bus.tstrb    = tstrb_v[g];
        assign bus.tvalid   = tvalid_v[g];
        assign bus.tlast    = tlast_v[g];
        assign tready_v[g]  = bus.tready;

        axis_seq_checker #(
            .DATA_SIZE   (32),
            .SEED        (P_SEED[g]),
            .PKT_LEN     (int'(P_LEN[g])),
            .THROTTLE    (int'(P_THR[g])),
            .STOP_ON_ERR (int'(P_STOP[g]))
        ) u_dut (
            .aclk           (aclk),
            .areset         (areset_v[g]),
            .enable         (enable_v[g]),
            .clear          (clear_v[g]),
            .s00_axis       (bus),
            .beat_count     (beat_v[g]),
            .pkt_count      (pkt_v[g]),
            .error_count    (err_v[g]),
            .err_flag       (flag_v[g]),
            .first_err_data (first_v[g]),
            .halted         (halted_v[g])
        );
    end

    // behavioural model state
    bit          m_run  [N];
    bit          m_halt [N];
    bit          m_flag [N];
    int          m_ridx [N];
    int          m_bip  [N];
    int          m_pkts [N];
    int          m_errs [N];
    logic [31:0] m_exp  [N];
    logic [31:0] m_beats[N];
    logic [31:0] m_first[N];

    int n_checks = 0;
    int n_errors = 0;
    int sent;
    int lows;
    bit acc_now;

    typedef struct {
        logic [31:0] data;
        logic        last;
        logic [3:0]  strb;
        int          beats;
        int          pkts;
        int          errs;
    } vec_t;
    vec_t tbl [15];

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit m_tready(int i);
        int thr;
        thr = int'(P_THR[i]);
        return m_run[i] && ((thr == 0) || ((m_ridx[i] % (thr + 1)) != thr));
    endfunction

    function automatic void m_clear_stats(int i);
        m_exp[i]   = P_SEED[i];
        m_beats[i] = 32'd0;
        m_first[i] = 32'd0;
        m_pkts[i]  = 0;
        m_errs[i]  = 0;
        m_flag[i]  = 1'b0;
        m_bip[i]   = 0;
        m_ridx[i]  = 0;
    endfunction

    task automatic model_step();
        for (int i = 0; i < N; i++) begin
            bit acc;
            bit err;
            acc = tvalid_v[i] && m_tready(i);
            err = 1'b0;
            if (areset_v[i]) begin
                m_clear_stats(i);
                m_run[i]  = 1'b0;
                m_halt[i] = 1'b0;
            end else if (clear_v[i]) begin
                m_run[i]  = enable_v[i] && !m_halt[i];
                m_halt[i] = 1'b0;
                m_clear_stats(i);
            end else begin
                if (m_run[i]) m_ridx[i]++;
                if (acc) begin
                    err = (tdata_v[i] != m_exp[i]) || (tstrb_v[i] != 4'hF) ||
                          ((P_LEN[i] != 8'd0) && (tlast_v[i] != (m_bip[i] == int'(P_LEN[i]) - 1)));
                    m_exp[i] = tdata_v[i] + 32'd1;
                    if (m_beats[i] != 32'hFFFF_FFFF) m_beats[i]++;
                    if (tlast_v[i]) begin
                        if (m_pkts[i] < 65535) m_pkts[i]++;
                        m_bip[i] = 0;
                    end else begin
                        m_bip[i]++;
                    end
                    if (err) begin
                        if (m_errs[i] < 65535) m_errs[i]++;
                        if (!m_flag[i]) begin
                            m_flag[i]  = 1'b1;
                            m_first[i] = tdata_v[i];
                        end
                    end
                end
                if (m_halt[i]) begin
                    m_halt[i] = 1'b1;
                end else if (acc && err && P_STOP[i]) begin
                    m_halt[i] = 1'b1;
                    m_run[i]  = 1'b0;
                end else begin
                    m_run[i] = enable_v[i];
                end
            end
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < N; i++) begin
            chk($sformatf("model_tready[%0d]", i), {31'd0, tready_v[i]}, {31'd0, m_tready(i)});
            chk($sformatf("model_beats[%0d]", i), beat_v[i], m_beats[i]);
            chk($sformatf("model_pkts[%0d]", i), {16'd0, pkt_v[i]}, m_pkts[i]);
            chk($sformatf("model_errs[%0d]", i), {16'd0, err_v[i]}, m_errs[i]);
            chk($sformatf("model_flag[%0d]", i), {31'd0, flag_v[i]}, {31'd0, m_flag[i]});
            chk($sformatf("model_first[%0d]", i), first_v[i], m_first[i]);
            chk($sformatf("model_halted[%0d]", i), {31'd0, halted_v[i]}, {31'd0, m_halt[i]});
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        model_step();
        @(negedge aclk);
        check_all();
    endtask

    task automatic send(int i, logic [31:0] d, logic l, logic [3:0] s);
        int waited;
        waited = 0;
        tdata_v[i]  = d;
        tlast_v[i]  = l;
        tstrb_v[i]  = s;
        tvalid_v[i] = 1'b1;
        while ((tready_v[i] !== 1'b1) && (waited < 20)) begin
            tick();
            waited++;
        end
        if (waited >= 20) begin
            n_checks++;
            n_errors++;
            $display("FAIL send_timeout[%0d]: tready got %b, required 1", i, tready_v[i]);
        end
        tick();
        tvalid_v[i] = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            areset_v[i] = 1'b1;
            enable_v[i] = 1'b0;
            clear_v[i]  = 1'b0;
            tvalid_v[i] = 1'b0;
            tlast_v[i]  = 1'b0;
            tdata_v[i]  = 32'd0;
            tstrb_v[i]  = 4'hF;
        end
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            chk("rst_tready", {31'd0, tready_v[i]}, 32'd0);
            chk("rst_beats", beat_v[i], 32'd0);
            chk("rst_pkts", {16'd0, pkt_v[i]}, 32'd0);
            chk("rst_errs", {16'd0, err_v[i]}, 32'd0);
            chk("rst_flag", {31'd0, flag_v[i]}, 32'd0);
            chk("rst_first", first_v[i], 32'd0);
            chk("rst_halted", {31'd0, halted_v[i]}, 32'd0);
            areset_v[i] = 1'b0;
        end

        // clean stream of three 4-beat packets
        enable_v[0] = 1'b1;
        chk("t1_tready_before", {31'd0, tready_v[0]}, 32'd0);
        tick();
        chk("t1_tready_rise", {31'd0, tready_v[0]}, 32'd1);
        for (int k = 0; k < 12; k++) send(0, k, (k % 4) == 3, 4'hF);
        chk("t1_beats", beat_v[0], 32'd12);
        chk("t1_pkts", {16'd0, pkt_v[0]}, 32'd3);
        chk("t1_errs", {16'd0, err_v[0]}, 32'd0);
        chk("t1_flag", {31'd0, flag_v[0]}, 32'd0);

        // framing, data, strobe and multi-fault beats
        tbl[0]  = '{32'd12, 1'b0, 4'hF, 13, 3, 0};
        tbl[1]  = '{32'd13, 1'b0, 4'hF, 14, 3, 0};
        tbl[2]  = '{32'd14, 1'b1, 4'hF, 15, 4, 1};
        tbl[3]  = '{32'd15, 1'b0, 4'hF, 16, 4, 1};
        tbl[4]  = '{32'd16, 1'b0, 4'hF, 17, 4, 1};
        tbl[5]  = '{32'd17, 1'b0, 4'hF, 18, 4, 1};
        tbl[6]  = '{32'd18, 1'b1, 4'hF, 19, 5, 1};
        tbl[7]  = '{32'd20, 1'b0, 4'hF, 20, 5, 2};
        tbl[8]  = '{32'd21, 1'b0, 4'hF, 21, 5, 2};
        tbl[9]  = '{32'd22, 1'b0, 4'hF, 22, 5, 2};
        tbl[10] = '{32'd23, 1'b1, 4'hF, 23, 6, 2};
        tbl[11] = '{32'd24, 1'b0, 4'hE, 24, 6, 3};
        tbl[12] = '{32'd25, 1'b0, 4'hF, 25, 6, 3};
        tbl[13] = '{32'd29, 1'b1, 4'h0, 26, 7, 4};
        tbl[14] = '{32'd30, 1'b0, 4'hF, 27, 7, 4};
        for (int k = 0; k < 15; k++) begin
            send(0, tbl[k].data, tbl[k].last, tbl[k].strb);
            chk($sformatf("tbl_beats[%0d]", k), beat_v[0], tbl[k].beats);
            chk($sformatf("tbl_pkts[%0d]", k), {16'd0, pkt_v[0]}, tbl[k].pkts);
            chk($sformatf("tbl_errs[%0d]", k), {16'd0, err_v[0]}, tbl[k].errs);
        end
        chk("tbl_first", first_v[0], 32'd14);

        // dropped word gives one error and resyncs
        enable_v[1] = 1'b1;
        tick();
        send(1, 32'd0, 1'b0, 4'hF);
        send(1, 32'd1, 1'b0, 4'hF);
        send(1, 32'd2, 1'b0, 4'hF);
        for (int k = 4; k < 8; k++) send(1, k, 1'b0, 4'hF);
        chk("t2_errs", {16'd0, err_v[1]}, 32'd1);
        chk("t2_first", first_v[1], 32'd4);
        send(1, 32'd8, 1'b0, 4'hF);
        send(1, 32'd9, 1'b0, 4'hF);
        chk("t2_errs_after", {16'd0, err_v[1]}, 32'd1);
        chk("t2_beats", beat_v[1], 32'd9);

        // throttle pattern over 40 always-valid cycles
        clear_v[1] = 1'b1;
        tick();
        clear_v[1] = 1'b0;
        chk("t4_clear_beats", beat_v[1], 32'd0);
        chk("t4_clear_errs", {16'd0, err_v[1]}, 32'd0);
        sent = 0;
        lows = 0;
        tvalid_v[1] = 1'b1;
        tlast_v[1]  = 1'b0;
        tstrb_v[1]  = 4'hF;
        for (int c = 0; c < 40; c++) begin
            tdata_v[1] = sent;
            acc_now = (tready_v[1] === 1'b1);
            if (!acc_now) lows++;
            chk("t4_pattern", {31'd0, tready_v[1]}, {31'd0, (c % 4) != 3});
            tick();
            if (acc_now) sent++;
        end
        tvalid_v[1] = 1'b0;
        tick();
        chk("t4_beats", beat_v[1], 32'd30);
        chk("t4_lows", lows, 32'd10);
        chk("t4_errs", {16'd0, err_v[1]}, 32'd0);

        // stop on error, then clear
        enable_v[2] = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) send(2, k, (k % 4) == 3, 4'hF);
        send(2, 32'd5, 1'b0, 4'h7);
        chk("t5_halted", {31'd0, halted_v[2]}, 32'd1);
        chk("t5_tready", {31'd0, tready_v[2]}, 32'd0);
        chk("t5_errs", {16'd0, err_v[2]}, 32'd1);
        chk("t5_first", first_v[2], 32'd5);
        tvalid_v[2] = 1'b1;
        tdata_v[2]  = 32'd6;
        tstrb_v[2]  = 4'hF;
        tick();
        tick();
        tick();
        tvalid_v[2] = 1'b0;
        chk("t5_hold_beats", beat_v[2], 32'd6);
        chk("t5_hold_halted", {31'd0, halted_v[2]}, 32'd1);
        clear_v[2] = 1'b1;
        tick();
        clear_v[2] = 1'b0;
        chk("t5_clr_beats", beat_v[2], 32'd0);
        chk("t5_clr_errs", {16'd0, err_v[2]}, 32'd0);
        chk("t5_clr_halted", {31'd0, halted_v[2]}, 32'd0);
        chk("t5_clr_idle", {31'd0, tready_v[2]}, 32'd0);
        tick();
        chk("t5_rerun", {31'd0, tready_v[2]}, 32'd1);
        send(2, 32'd0, 1'b0, 4'hF);
        chk("t5_seed_errs", {16'd0, err_v[2]}, 32'd0);
        chk("t5_seed_beats", beat_v[2], 32'd1);

        // data wrap from all-ones, then reset mid-stream
        enable_v[3] = 1'b1;
        tick();
        send(3, 32'hFFFF_FFFE, 1'b0, 4'hF);
        send(3, 32'hFFFF_FFFF, 1'b0, 4'hF);
        send(3, 32'h0000_0000, 1'b0, 4'hF);
        send(3, 32'h0000_0001, 1'b0, 4'hF);
        chk("t6_errs", {16'd0, err_v[3]}, 32'd0);
        chk("t6_beats", beat_v[3], 32'd4);
        tvalid_v[3] = 1'b1;
        tdata_v[3]  = 32'd2;
        areset_v[3] = 1'b1;
        tick();
        areset_v[3] = 1'b0;
        tvalid_v[3] = 1'b0;
        chk("t6_rst_tready", {31'd0, tready_v[3]}, 32'd0);
        chk("t6_rst_beats", beat_v[3], 32'd0);
        chk("t6_rst_errs", {16'd0, err_v[3]}, 32'd0);

        // random traffic against the model
        for (int c = 0; c < 1500; c++) begin
            for (int i = 0; i < N; i++) begin
                enable_v[i] = ($urandom_range(0, 15) != 0);
                clear_v[i]  = ($urandom_range(0, 99) == 0);
                areset_v[i] = ($urandom_range(0, 299) == 0);
                tvalid_v[i] = ($urandom_range(0, 3) != 0);
                tdata_v[i]  = ($urandom_range(0, 19) == 0) ? $urandom : m_exp[i];
                tstrb_v[i]  = ($urandom_range(0, 29) == 0) ? 4'($urandom) : 4'hF;
                if (P_LEN[i] == 8'd0) begin
                    tlast_v[i] = ($urandom_range(0, 7) == 0);
                end else begin
                    tlast_v[i] = ($urandom_range(0, 24) == 0) ^ (m_bip[i] == int'(P_LEN[i]) - 1);
                end
            end
            tick();
        end
        for (int i = 0; i < N; i++) begin
            areset_v[i] = 1'b0;
            clear_v[i]  = 1'b0;
            tvalid_v[i] = 1'b0;
        end
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axis_seq_checker.md
Name: axis_seq_checker

Overview:
- AXI-Stream sink at the far end of the generator → axis_fifo chain. It consumes the stream on the FIFO master side.
- Checks each accepted beat against the generator's incrementing sequence. Also checks tstrb and packet framing (tlast).
- Reports beat, packet and error statistics for lab bring-up.
- Applies a programmable tready throttle so that FIFO backpressure paths get exercised.

Parameters:
- DATA_SIZE, 32: width of tdata and of the expected-value counter.
- SEED, 0: first expected data value after reset or clear.
- PKT_LEN, 16: beats per packet; tlast is expected on beat PKT_LEN-1. Value 0 disables the tlast check.
- THROTTLE, 0: 0 holds tready high continuously in RUN. N>0 drops tready for 1 cycle out of every N+1.
- STOP_ON_ERR, 0: 1 makes the first error move the FSM to HALT.

Ports:
- aclk  in  1  clock, rising edge.
- areset  in  1  synchronous, active-high reset.
- enable  in  1  level; 1 = accept stream.
- clear  in  1  single-cycle synchronous clear of statistics and state.
- s00_axis_tdata  in  DATA_SIZE  stream data.
- s00_axis_tstrb  in  DATA_SIZE/8  byte strobes; all ones required.
- s00_axis_tvalid  in  1  source valid.
- s00_axis_tready  out  1  sink ready; registered.
- s00_axis_tlast  in  1  end of packet.
- beat_count  out  32  accepted beats; saturating.
- pkt_count  out  16  accepted tlast beats; saturating.
- error_count  out  16  errored beats; saturating.
- err_flag  out  1  sticky; set on the first error.
- first_err_data  out  DATA_SIZE  tdata of the first errored beat.
- halted  out  1  1 while in HALT.

Behaviour:
- Reset (areset=1 at a clock edge) forces the following values:
  - state IDLE, tready 0.
  - all counts 0, err_flag 0, first_err_data 0, halted 0.
  - expected = SEED, beat_in_pkt = 0, throttle counter = 0.
- State IDLE:
  - tready = 0.
  - enable=1 → RUN on the next cycle, so tready rises 1 cycle after enable.
- State RUN:
  - tready driven by the throttle. Throttle counter increments every RUN cycle regardless of tvalid and wraps at THROTTLE.
  - tready = 0 in the cycle the counter equals THROTTLE.
  - enable=0 → IDLE; tready falls the next cycle. A beat accepted in that same cycle is still fully processed.
- State HALT (reachable only when STOP_ON_ERR=1):
  - tready = 0, halted = 1.
  - Left only via clear or reset, both → IDLE.
- Acceptance: a beat is accepted when tvalid & tready at the clock edge. Exactly one beat per cycle at most.
- Checks on an accepted beat. Each beat counts at most one error even if several checks fail:
  - data error: tdata != expected.
  - strb error: tstrb != all ones.
  - framing error (PKT_LEN>0 only), either of:
    - tlast=1 with beat_in_pkt != PKT_LEN-1;
    - tlast=0 with beat_in_pkt == PKT_LEN-1.
- Update on an accepted beat; status outputs are visible 1 cycle after acceptance:
  - expected ← tdata+1, modulo 2^DATA_SIZE. This resyncs after a mismatch, so one dropped word yields exactly one error. Wrap from all-ones to 0 is legal.
  - beat_count +1.
  - tlast=1: pkt_count +1, beat_in_pkt ← 0. Otherwise beat_in_pkt +1.
  - Error: error_count +1. If err_flag was 0: err_flag ← 1 and first_err_data ← tdata. If STOP_ON_ERR=1: state ← HALT.
- Saturation: counters hold at their maximum value and never wrap.
- clear=1 (areset has priority over clear):
  - same effect as reset on statistics, expected, beat_in_pkt and throttle.
  - state ← IDLE if enable=0 or HALT, otherwise stays in RUN.
  - A beat accepted in the clear cycle is discarded: not counted, and expected = SEED afterwards.
- tvalid held with tready low: no state change and no check.

Decomposition:
- Shared package holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_HALT=2'd2;
  - counter widths CNT_W=32 and STAT_W=16.
- One natural sub-module: axis_ready_throttle (counter plus tready pattern generation, THROTTLE parameter). The checker FSM and statistics stay in the top module.

Test Plan:
- Reset, then enable=1, SEED=0, PKT_LEN=4, THROTTLE=0; source sends 0..11 continuously with tlast on 3, 7, 11 → tready rises 1 cycle after enable; beat_count=12, pkt_count=3, error_count=0, err_flag=0.
- Sequence 0,1,2,4,5,6,7 with PKT_LEN=0 → error_count=1, first_err_data=4, expected=8 at the end; no further errors.
- PKT_LEN=4; tlast on beat 2 (early), then 4 clean beats with tlast on the 4th → error_count=1, pkt_count=2.
- THROTTLE=3, source always valid for 40 cycles in RUN → tready low exactly 1 of every 4 cycles; beat_count=30; sequence intact.
- STOP_ON_ERR=1, tstrb=4'b0111 on beat 5 → halted=1 and tready=0 from the next cycle, error_count=1. Then clear=1 → all counts 0, state IDLE→RUN, expected=SEED.
- SEED=32'hFFFF_FFFE, send FFFF_FFFE, FFFF_FFFF, 0, 1 → error_count=0 (wrap legal). Assert areset in RUN mid-stream → tready=0 and all counts 0 on the next cycle.
